sdram_arbiter: RTL

//  Shares the single SDRAM controller port between the video scan-out master (port V, read bursts)
//  and the CPU bus master (port C, single-word read/write). Fixed priority to V, with a bounded

---
 rtl/sdram_pkg.sv | 33 +++
 rtl/sdram_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM port-sharing logic.
//   sdram_cmd_t  : command fields presented to the SDRAM controller
//   sdram_resp_t : response beat returned by the SDRAM controller
//   arb_state_e  : arbiter ownership state
//   arb_win_e    : combinational winner of the idle-time arbitration
package sdram_pkg;

  typedef struct packed {
    logic        we;
    logic [23:0] addr_x16;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } sdram_cmd_t;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] rdata;
  } sdram_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_V = 2'd1,
    BUSY_C = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_V    = 2'd1,
    WIN_C    = 2'd2
  } arb_win_e;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM controller port between the video scan-out master (V,
// read bursts) and the CPU bus master (C, single-word read/write).
// V has fixed priority, but after MAX_V_STREAK consecutive V grants while C
// is waiting, C wins once. The grant is held from command accept until the
// owner pulses its ack; if the owner never acks, the grant is force-released
// ACK_TIMEOUT cycles after the owner's last response word and err_timeout_o
// latches until reset.
// Ports:
//   clk_i, rst_i                        clock, async active-high reset
//   v_cmd_*, v_addr_x16, v_ack          V command handshake and release
//   v_resp_*, v_rdata, v_rdy            V response path, controller-ready copy
//   c_cmd_*, c_we/addr/wdata/wmask      C command handshake and fields
//   c_ack, c_resp_*, c_rdata, c_rdy     C release, response path, ready copy
//   mem_cmd_*, mem_we/addr/wdata/wmask  muxed command to the controller
//   mem_rdy, mem_ack                    controller ready, release to controller
//   mem_resp_valid/last/rdata           controller response
//   err_timeout_o                       sticky forced-release flag
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned MAX_V_STREAK = 4,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // V port
  input  logic        v_cmd_valid,
  output logic        v_cmd_ready,
  output logic        v_rdy,
  input  logic        v_ack,
  input  logic [23:0] v_addr_x16,
  output logic        v_resp_valid,
  output logic        v_resp_last,
  output logic [15:0] v_rdata,
  // C port
  input  logic        c_cmd_valid,
  output logic        c_cmd_ready,
  output logic        c_rdy,
  input  logic        c_ack,
  input  logic        c_we,
  input  logic [23:0] c_addr_x16,
  input  logic [15:0] c_wdata,
  input  logic [1:0]  c_wmask,
  output logic        c_resp_valid,
  output logic        c_resp_last,
  output logic [15:0] c_rdata,
  // SDRAM controller
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  input  logic        mem_rdy,
  output logic        mem_ack,
  output logic        mem_we,
  output logic [23:0] mem_addr_x16,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic        mem_resp_last,
  input  logic [15:0] mem_resp_rdata,
  output logic        err_timeout_o
);

  localparam int unsigned STREAK_W = (MAX_V_STREAK < 1) ? 1 : $clog2(MAX_V_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_V_STREAK);
  localparam logic [7:0]          TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  arb_state_e          state;
  arb_win_e            win;
  logic [STREAK_W-1:0] streak;
  logic                last_seen;
  logic [7:0]          to_cnt;

  sdram_cmd_t  v_cmd, c_cmd, mem_cmd;
  sdram_resp_t mem_resp;

  logic own_v, own_c, grant, owner_ack, owner_last, timeout_hit;

  assign v_cmd    = '{we: 1'b0, addr_x16: v_addr_x16, wdata: '0, wmask: 2'b11};
  assign c_cmd    = '{we: c_we, addr_x16: c_addr_x16, wdata: c_wdata, wmask: c_wmask};
  assign mem_resp = '{valid: mem_resp_valid, last: mem_resp_last, rdata: mem_resp_rdata};

  assign own_v = (state == BUSY_V);
  assign own_c = (state == BUSY_C);

  // Idle-time arbitration. Combinational outputs are masked while rst_i is
  // high so every output reads 0 during reset regardless of input activity.
  always_comb begin
    win = WIN_NONE;
    if (!rst_i && state == IDLE && mem_rdy) begin
      if (v_cmd_valid && !(c_cmd_valid && streak == STREAK_MAX)) win = WIN_V;
      else if (c_cmd_valid)                                       win = WIN_C;
    end
  end

  always_comb begin
    mem_cmd       = '0;
    mem_cmd_valid = 1'b0;
    v_cmd_ready   = 1'b0;
    c_cmd_ready   = 1'b0;
    unique case (win)
      WIN_V: begin
        mem_cmd       = v_cmd;
        mem_cmd_valid = 1'b1;
        v_cmd_ready   = mem_cmd_ready;
      end
      WIN_C: begin
        mem_cmd       = c_cmd;
        mem_cmd_valid = 1'b1;
        c_cmd_ready   = mem_cmd_ready;
      end
      default: ;
    endcase
  end

  assign mem_we       = mem_cmd.we;
  assign mem_addr_x16 = mem_cmd.addr_x16;
  assign mem_wdata    = mem_cmd.wdata;
  assign mem_wmask    = mem_cmd.wmask;

  assign grant = mem_cmd_valid && mem_cmd_ready;

  // Responses only reach the current owner; a beat arriving in IDLE is dropped.
  assign v_resp_valid = own_v && mem_resp.valid;
  assign v_resp_last  = own_v && mem_resp.valid && mem_resp.last;
  assign v_rdata      = own_v ? mem_resp.rdata : '0;
  assign c_resp_valid = own_c && mem_resp.valid;
  assign c_resp_last  = own_c && mem_resp.valid && mem_resp.last;
  assign c_rdata      = own_c ? mem_resp.rdata : '0;

  assign v_rdy = mem_rdy && !rst_i;
  assign c_rdy = mem_rdy && !rst_i;

  assign owner_ack   = (own_v && v_ack) || (own_c && c_ack);
  assign owner_last  = (own_v || own_c) && mem_resp.valid && mem_resp.last;
  // to_cnt equals the number of cycles elapsed since the resp_last cycle.
  assign timeout_hit = (own_v || own_c) && last_seen && (to_cnt == TIMEOUT_CNT);
  assign mem_ack     = owner_ack || timeout_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      streak        <= '0;
      last_seen     <= 1'b0;
      to_cnt        <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state     <= (win == WIN_V) ? BUSY_V : BUSY_C;
            last_seen <= 1'b0;
            to_cnt    <= '0;
            if (win == WIN_C || !c_cmd_valid) streak <= '0;
            else if (streak != STREAK_MAX)    streak <= streak + STREAK_W'(1);
          end
        end
        BUSY_V, BUSY_C: begin
          if (mem_ack) begin
            state     <= IDLE;
            last_seen <= 1'b0;
            to_cnt    <= '0;
            if (!owner_ack) err_timeout_o <= 1'b1;
          end else if (last_seen) begin
            to_cnt <= to_cnt + 8'd1;
          end else if (owner_last) begin
            last_seen <= 1'b1;
            to_cnt    <= 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
